// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch stage: owns the PC, issues reads to a
// synchronous 1-cycle-latency program RAM, buffers the returned words in a
// small FIFO and presents them to decode over a valid/ready handshake.
// Taken branches/jumps flush the buffer and drop any read still in flight.
//
// Optional feature: define FETCH_PERF_EN to add saturating performance
// counters PerfFetchCnt (instructions handed to decode) and PerfStallCnt
// (cycles with nothing to present and no redirect).
//
// Ports:
//   Clk          clock, rising edge
//   Reset        asynchronous, active-high reset
//   MemRdEn      program RAM read strobe
//   MemAddr      program RAM word address (Pc[MEM_ADDR_BITS+1:2])
//   MemRdData    RAM read data, valid the cycle after MemRdEn
//   RedirectEn   taken branch/jump from execute
//   RedirectPc   redirect target, bits [1:0] forced to zero
//   InstrValid   buffer head valid
//   InstrReady   decode accepts the head
//   Instr        head instruction
//   InstrPc      PC of the head instruction
//   PerfFetchCnt / PerfStallCnt  (FETCH_PERF_EN only) performance counters
module fetch_unit #(
  parameter int PC_WIDTH      = 32,
  parameter int INSTR_WIDTH   = 32,
  parameter int MEM_ADDR_BITS = 9,
  parameter int FIFO_DEPTH    = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                     Clk,
  input  logic                     Reset,
  output logic                     MemRdEn,
  output logic [MEM_ADDR_BITS-1:0] MemAddr,
  input  logic [INSTR_WIDTH-1:0]   MemRdData,
  input  logic                     RedirectEn,
  input  logic [PC_WIDTH-1:0]      RedirectPc,
  output logic                     InstrValid,
  input  logic                     InstrReady,
  output logic [INSTR_WIDTH-1:0]   Instr,
  output logic [PC_WIDTH-1:0]      InstrPc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]              PerfFetchCnt,
  output logic [31:0]              PerfStallCnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0]    DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~(PC_WIDTH'(3));

  logic [PC_WIDTH-1:0]    pc_r;
  logic [PC_WIDTH-1:0]    inflightPc_r;
  logic                   inflight_r;
  logic [CNT_W-1:0]       count_r;
  logic [PTR_W-1:0]       rdPtr_r;
  logic [PTR_W-1:0]       wrPtr_r;
  logic [INSTR_WIDTH-1:0] instrMem_r [FIFO_DEPTH];
  logic [PC_WIDTH-1:0]    pcMem_r    [FIFO_DEPTH];

  logic [CNT_W:0] credit_s;
  logic           issue_s;
  logic           push_s;
  logic           pop_s;

  // Issue/push/pop decisions and the combinational output views.
  always_comb begin
    // Buffered entries plus the read still in flight must leave room;
    // a pop in this same cycle is deliberately not credited.
    credit_s   = {1'b0, count_r} + {{CNT_W{1'b0}}, inflight_r};
    issue_s    = !RedirectEn && (credit_s < DEPTH_C);
    push_s     = inflight_r && !RedirectEn;
    InstrValid = (count_r != '0);
    pop_s      = InstrValid && InstrReady && !RedirectEn;
    // Reset gates the strobe so a held reset never reads the RAM.
    MemRdEn    = issue_s && !Reset;
    if (MemRdEn) begin
      MemAddr = pc_r[MEM_ADDR_BITS+1:2];
    end else begin
      MemAddr = '0;
    end
    if (InstrValid) begin
      Instr   = instrMem_r[rdPtr_r];
      InstrPc = pcMem_r[rdPtr_r];
    end else begin
      Instr   = '0;
      InstrPc = '0;
    end
  end

  // PC, in-flight tracking and instruction buffer state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc_r         <= RESET_PC;
      inflightPc_r <= '0;
      inflight_r   <= 1'b0;
      count_r      <= '0;
      rdPtr_r      <= '0;
      wrPtr_r      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instrMem_r[i] <= '0;
        pcMem_r[i]    <= '0;
      end
    end else if (RedirectEn) begin
      // Flush wins over issue, push and pop alike.
      pc_r       <= RedirectPc & ALIGN_MASK;
      inflight_r <= 1'b0;
      count_r    <= '0;
      rdPtr_r    <= '0;
      wrPtr_r    <= '0;
    end else begin
      inflight_r <= issue_s;
      if (issue_s) begin
        pc_r         <= pc_r + PC_STEP;
        inflightPc_r <= pc_r;
      end else begin
        pc_r         <= pc_r;
        inflightPc_r <= inflightPc_r;
      end
      if (push_s) begin
        instrMem_r[wrPtr_r] <= MemRdData;
        pcMem_r[wrPtr_r]    <= inflightPc_r;
        wrPtr_r             <= wrPtr_r + PTR_W'(1);
      end else begin
        wrPtr_r <= wrPtr_r;
      end
      if (pop_s) begin
        rdPtr_r <= rdPtr_r + PTR_W'(1);
      end else begin
        rdPtr_r <= rdPtr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic stall_s;

  // Stall qualifier: nothing to present and not being redirected.
  always_comb begin
    stall_s = !InstrValid && !RedirectEn;
  end

  // Saturating performance counters.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      PerfFetchCnt <= 32'd0;
      PerfStallCnt <= 32'd0;
    end else begin
      if (pop_s && (PerfFetchCnt != 32'hFFFF_FFFF)) begin
        PerfFetchCnt <= PerfFetchCnt + 32'd1;
      end else begin
        PerfFetchCnt <= PerfFetchCnt;
      end
      if (stall_s && (PerfStallCnt != 32'hFFFF_FFFF)) begin
        PerfStallCnt <= PerfStallCnt + 32'd1;
      end else begin
        PerfStallCnt <= PerfStallCnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- directed bench for fetch_unit. Two instances share the
// clock and reset: "dut" (RESET_PC=0) takes the directed handshake/redirect
// sequence, "dut2" (RESET_PC=0xFFFFFFF8) streams freely to show PC wrap.
// Each program RAM returns 0xC0DE0000 | word address one cycle after a read.
module tb_fetch_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        RedirectEn;
  logic [31:0] RedirectPc;
  logic        InstrReady;
  logic        MemRdEn;
  logic [8:0]  MemAddr;
  logic [31:0] MemRdData;
  logic        InstrValid;
  logic [31:0] Instr;
  logic [31:0] InstrPc;

  logic        memRdEn2;
  logic [8:0]  memAddr2;
  logic [31:0] memRdData2;
  logic        instrValid2;
  logic [31:0] instr2;
  logic [31:0] instrPc2;

`ifdef FETCH_PERF_EN
  logic [31:0] PerfFetchCnt;
  logic [31:0] PerfStallCnt;
  logic [31:0] perfFetchCnt2;
  logic [31:0] perfStallCnt2;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 Clk = ~Clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .Clk(Clk), .Reset(Reset),
    .MemRdEn(MemRdEn), .MemAddr(MemAddr), .MemRdData(MemRdData),
    .RedirectEn(RedirectEn), .RedirectPc(RedirectPc),
    .InstrValid(InstrValid), .InstrReady(InstrReady),
    .Instr(Instr), .InstrPc(InstrPc)
`ifdef FETCH_PERF_EN
    , .PerfFetchCnt(PerfFetchCnt), .PerfStallCnt(PerfStallCnt)
`endif
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .Clk(Clk), .Reset(Reset),
    .MemRdEn(memRdEn2), .MemAddr(memAddr2), .MemRdData(memRdData2),
    .RedirectEn(1'b0), .RedirectPc(32'h0000_0000),
    .InstrValid(instrValid2), .InstrReady(1'b1),
    .Instr(instr2), .InstrPc(instrPc2)
`ifdef FETCH_PERF_EN
    , .PerfFetchCnt(perfFetchCnt2), .PerfStallCnt(perfStallCnt2)
`endif
  );

  // Program RAM models: synchronous read, one cycle latency.
  always @(posedge Clk) begin
    if (MemRdEn) MemRdData <= 32'hC0DE_0000 | {23'd0, MemAddr};
    if (memRdEn2) memRdData2 <= 32'hC0DE_0000 | {23'd0, memAddr2};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle, drive its inputs, let combinational outputs settle.
  task automatic cyc(input logic rdy, input logic re, input logic [31:0] rpc);
    @(posedge Clk);
    #1;
    InstrReady = rdy;
    RedirectEn = re;
    RedirectPc = rpc;
    #1;
  endtask

  initial begin
    Reset      = 1'b1;
    RedirectEn = 1'b0;
    RedirectPc = 32'h0;
    InstrReady = 1'b0;

    // Reset state
    @(posedge Clk); #1;
    chk("rst_valid",   {63'd0, InstrValid}, 64'd0);
    chk("rst_rden",    {63'd0, MemRdEn},    64'd0);
    chk("rst_addr",    {55'd0, MemAddr},    64'd0);
    chk("rst_instr",   {32'd0, Instr},      64'd0);
    chk("rst_ipc",     {32'd0, InstrPc},    64'd0);
    chk("rst_addr2",   {55'd0, memAddr2},   64'd0);
    chk("rst_valid2",  {63'd0, instrValid2}, 64'd0);
`ifdef FETCH_PERF_EN
    chk("rst_pfetch",  {32'd0, PerfFetchCnt}, 64'd0);
    chk("rst_pstall",  {32'd0, PerfStallCnt}, 64'd0);
`endif

    // Release: cycle 0 issues word 0 immediately
    @(posedge Clk); #1;
    Reset = 1'b0; InstrReady = 1'b1; #1;
    chk("c0_rden",  {63'd0, MemRdEn},  64'd1);
    chk("c0_addr",  {55'd0, MemAddr},  64'd0);
    chk("c0_valid", {63'd0, InstrValid}, 64'd0);
    chk("c0_addr2", {55'd0, memAddr2}, 64'h1FE);
    cyc(1'b1, 1'b0, 32'h0);
    chk("c1_addr",  {55'd0, MemAddr},  64'd1);
    chk("c1_valid", {63'd0, InstrValid}, 64'd0);
    cyc(1'b1, 1'b0, 32'h0);
    chk("c2_valid", {63'd0, InstrValid}, 64'd1);
    chk("c2_ipc",   {32'd0, InstrPc},  64'h0);
    chk("c2_instr", {32'd0, Instr},    64'hC0DE_0000);
    chk("c2_ipc2",  {32'd0, instrPc2}, 64'hFFFF_FFF8);
    chk("c2_instr2",{32'd0, instr2},   64'hC0DE_01FE);
    cyc(1'b1, 1'b0, 32'h0);
    chk("c3_ipc",   {32'd0, InstrPc},  64'h4);
    chk("c3_ipc2",  {32'd0, instrPc2}, 64'hFFFF_FFFC);
    cyc(1'b1, 1'b0, 32'h0);
    chk("c4_ipc",   {32'd0, InstrPc},  64'h8);
    chk("c4_ipc2",  {32'd0, instrPc2}, 64'h0);
    chk("c4_instr2",{32'd0, instr2},   64'hC0DE_0000);
    cyc(1'b1, 1'b0, 32'h0);
    chk("c5_ipc",   {32'd0, InstrPc},  64'hC);

    // Backpressure for 10 cycles: buffer fills, issue stops from cycle 8
    for (int k = 6; k <= 15; k++) begin
      cyc(1'b0, 1'b0, 32'h0);
      chk("bp_valid", {63'd0, InstrValid}, 64'd1);
      chk("bp_ipc",   {32'd0, InstrPc},    64'h10);
      chk("bp_rden",  {63'd0, MemRdEn},    (k < 8) ? 64'd1 : 64'd0);
    end
    // Release: pop in cycle 16 is not credited, issue resumes at 17
    for (int k = 16; k <= 20; k++) begin
      cyc(1'b1, 1'b0, 32'h0);
      chk("rel_ipc",  {32'd0, InstrPc}, 64'h10 + 64'(4 * (k - 16)));
      chk("rel_rden", {63'd0, MemRdEn}, (k >= 17) ? 64'd1 : 64'd0);
      if (k == 17) chk("rel_addr", {55'd0, MemAddr}, 64'h8);
    end

    // Asynchronous reset mid-stream
    @(posedge Clk); #1;
    Reset = 1'b1; #1;
    chk("ar_valid",  {63'd0, InstrValid},  64'd0);
    chk("ar_rden",   {63'd0, MemRdEn},     64'd0);
    chk("ar_addr",   {55'd0, MemAddr},     64'd0);
    chk("ar_valid2", {63'd0, instrValid2}, 64'd0);
    chk("ar_rden2",  {63'd0, memRdEn2},    64'd0);
    @(posedge Clk); #1;
    Reset = 1'b0; InstrReady = 1'b1; #1;            // cycle 0'
    chk("r0_addr", {55'd0, MemAddr}, 64'd0);
    cyc(1'b1, 1'b0, 32'h0);                         // cycle 1'
    cyc(1'b1, 1'b0, 32'h0);                         // cycle 2': pop 0x0
    chk("r2_ipc", {32'd0, InstrPc}, 64'h0);
    cyc(1'b0, 1'b0, 32'h0);                         // cycle 3': issue 0xC
    chk("r3_ipc",  {32'd0, InstrPc}, 64'h4);
    chk("r3_addr", {55'd0, MemAddr}, 64'h3);

    // Redirect with 0xC in flight and {0x4,0x8} buffered
    cyc(1'b0, 1'b1, 32'h0000_0103);                 // cycle 4'
    chk("rd_rden",  {63'd0, MemRdEn},    64'd0);
    chk("rd_valid", {63'd0, InstrValid}, 64'd1);
    cyc(1'b1, 1'b0, 32'h0);                         // cycle 5'
    chk("rd1_valid", {63'd0, InstrValid}, 64'd0);
    chk("rd1_addr",  {55'd0, MemAddr},    64'h40);
    cyc(1'b1, 1'b0, 32'h0);                         // cycle 6'
    chk("rd2_valid", {63'd0, InstrValid}, 64'd0);
    cyc(1'b1, 1'b0, 32'h0);                         // cycle 7'
    chk("rd3_valid", {63'd0, InstrValid}, 64'd1);
    chk("rd3_ipc",   {32'd0, InstrPc},    64'h100);
    chk("rd3_instr", {32'd0, Instr},      64'hC0DE_0040);

    // Redirect coinciding with a pop, then a second redirect next cycle
    cyc(1'b1, 1'b1, 32'h0000_0200);                 // cycle 8'
    chk("bb_ipc",  {32'd0, InstrPc}, 64'h104);
    chk("bb_rden", {63'd0, MemRdEn}, 64'd0);
    cyc(1'b1, 1'b1, 32'h0000_0300);                 // cycle 9'
    chk("bb1_valid", {63'd0, InstrValid}, 64'd0);
    chk("bb1_rden",  {63'd0, MemRdEn},    64'd0);
    cyc(1'b1, 1'b0, 32'h0);                         // cycle 10'
    chk("bb2_addr",  {55'd0, MemAddr},    64'hC0);
    chk("bb2_valid", {63'd0, InstrValid}, 64'd0);
    cyc(1'b1, 1'b0, 32'h0);                         // cycle 11'
    chk("bb3_valid", {63'd0, InstrValid}, 64'd0);
    cyc(1'b1, 1'b0, 32'h0);                         // cycle 12'
    chk("bb4_ipc", {32'd0, InstrPc}, 64'h300);
    cyc(1'b1, 1'b0, 32'h0);                         // cycle 13'
    chk("bb5_ipc", {32'd0, InstrPc}, 64'h304);
`ifdef FETCH_PERF_EN
    chk("pf_fetch", {32'd0, PerfFetchCnt}, 64'd3);
    chk("pf_stall", {32'd0, PerfStallCnt}, 64'd6);
`endif
    for (int k = 14; k <= 21; k++) begin
      cyc(1'b1, 1'b0, 32'h0);
      chk("st_ipc", {32'd0, InstrPc}, 64'h304 + 64'(4 * (k - 13)));
    end
    cyc(1'b1, 1'b0, 32'h0);                         // cycle 22'
`ifdef FETCH_PERF_EN
    chk("pf_fetch2", {32'd0, PerfFetchCnt}, 64'd12);
    chk("pf_stall2", {32'd0, PerfStallCnt}, 64'd6);
`endif
    chk("end_valid", {63'd0, InstrValid}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
